// File: rtl/slice_sched_pkg.sv
// Shared types and helpers for the slice write scheduler: FSM states,
// the slice mask encoding and the slice width derived from register width.
package slice_sched_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LO   = 2'd1,
    HI   = 2'd2,
    ACK  = 2'd3
  } state_e;

  typedef logic [1:0] mask_t;

  localparam mask_t MASK_LO = 2'b01;
  localparam mask_t MASK_HI = 2'b10;

  function automatic int slice_w(input int w);
    return w / 2;
  endfunction

endpackage

// File: rtl/slice_write_sched_rr_arb.sv
// Combinational round-robin picker: first requester at or after ptr,
// wrapping modulo N_REQ. Returns a one-hot grant and its binary index.
module rr_arb #(
  parameter int N_REQ = 2,
  parameter int IW    = $clog2(N_REQ)
) (
  input  logic [N_REQ-1:0] req,
  input  logic [IW-1:0]    ptr,
  output logic [N_REQ-1:0] gnt,
  output logic [IW-1:0]    idx
);

  logic found;

  always_comb begin
    gnt   = '0;
    idx   = '0;
    found = 1'b0;
    // Indices at or above the pointer take priority, then wrap to the bottom.
    for (int k = 0; k < N_REQ; k++) begin
      if (!found && req[k] && (k >= int'(ptr))) begin
        found  = 1'b1;
        gnt[k] = 1'b1;
        idx    = IW'(k);
      end
    end
    for (int k = 0; k < N_REQ; k++) begin
      if (!found && req[k] && (k < int'(ptr))) begin
        found  = 1'b1;
        gnt[k] = 1'b1;
        idx    = IW'(k);
      end
    end
  end

endmodule

// File: rtl/slice_write_sched.sv
// Round-robin write scheduler for a W-bit register written as two half slices.
//   state | meaning
//   IDLE  | waiting for a request; picks owner and latches its mask/data
//   LO    | writes LSB slice from latched data
//   HI    | writes MSB slice from latched data
//   ACK   | one-cycle ack to owner, advance round-robin pointer
module slice_write_sched
  import slice_sched_pkg::*;
#(
  parameter int N_REQ = 2,
  parameter int W     = 8
) (
  input  logic               i_clk,
  input  logic               i_rst,
  input  logic [N_REQ-1:0]   i_req,
  input  logic [2*N_REQ-1:0] i_mask,
  input  logic [W*N_REQ-1:0] i_wdata,
  output logic [N_REQ-1:0]   o_gnt,
  output logic [N_REQ-1:0]   o_ack,
  output logic               o_busy,
  output logic [W-1:0]       o_data
);

  localparam int SW = slice_w(W);
  localparam int IW = $clog2(N_REQ);

  state_e           state;
  logic [IW-1:0]    ptr;
  logic [IW-1:0]    lat_idx;
  mask_t            lat_mask;
  logic [W-1:0]     lat_data;
  logic [W-1:0]     data_q;

  logic [N_REQ-1:0] pick_gnt;
  logic [IW-1:0]    pick_idx;
  mask_t            pick_mask;
  logic [W-1:0]     pick_data;

  rr_arb #(.N_REQ(N_REQ), .IW(IW)) u_arb (
    .req (i_req),
    .ptr (ptr),
    .gnt (pick_gnt),
    .idx (pick_idx)
  );

  // One-hot select of the picked requester's mask and data.
  always_comb begin
    pick_mask = '0;
    pick_data = '0;
    for (int k = 0; k < N_REQ; k++) begin
      if (pick_gnt[k]) begin
        pick_mask = i_mask[2*k +: 2];
        pick_data = i_wdata[k*W +: W];
      end
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state    <= IDLE;
      ptr      <= '0;
      lat_idx  <= '0;
      lat_mask <= '0;
      lat_data <= '0;
      data_q   <= '0;
      o_gnt    <= '0;
      o_ack    <= '0;
      o_busy   <= 1'b0;
    end else begin
      o_ack <= '0;
      case (state)
        IDLE: begin
          if (|i_req) begin
            lat_idx  <= pick_idx;
            lat_mask <= pick_mask;
            lat_data <= pick_data;
            o_gnt    <= pick_gnt;
            o_busy   <= 1'b1;
            if ((pick_mask & MASK_LO) != 2'b00) begin
              state <= LO;
            end else if ((pick_mask & MASK_HI) != 2'b00) begin
              state <= HI;
            end else begin
              state <= ACK;
              o_ack <= pick_gnt;
            end
          end
        end
        LO: begin
          data_q[SW-1:0] <= lat_data[SW-1:0];
          if ((lat_mask & MASK_HI) != 2'b00) begin
            state <= HI;
          end else begin
            state <= ACK;
            o_ack <= o_gnt;
          end
        end
        HI: begin
          data_q[W-1:SW] <= lat_data[W-1:SW];
          state          <= ACK;
          o_ack          <= o_gnt;
        end
        ACK: begin
          state  <= IDLE;
          o_gnt  <= '0;
          o_busy <= 1'b0;
          ptr    <= (lat_idx == IW'(N_REQ-1)) ? '0 : lat_idx + 1'b1;
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign o_data = data_q;

endmodule

// File: tb/tb_slice_write_sched.sv
// Directed bench for slice_write_sched with N_REQ=2, W=8.
module tb_slice_write_sched;

  logic        clk;
  logic        rst;
  logic [1:0]  req;
  logic [3:0]  mask;
  logic [15:0] wdata;
  logic [1:0]  gnt;
  logic [1:0]  ack;
  logic        busy;
  logic [7:0]  data;

  int n_cmp;
  int n_err;

  slice_write_sched #(.N_REQ(2), .W(8)) dut (
    .i_clk   (clk),
    .i_rst   (rst),
    .i_req   (req),
    .i_mask  (mask),
    .i_wdata (wdata),
    .o_gnt   (gnt),
    .o_ack   (ack),
    .o_busy  (busy),
    .o_data  (data)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  initial begin
    logic [1:0] exp_owner;
    logic       got;
    n_cmp = 0;
    n_err = 0;
    rst   = 1'b1;
    req   = '0;
    mask  = '0;
    wdata = '0;

    // 1: reset then idle
    @(negedge clk);
    step();
    step();
    rst = 1'b0;
    for (int i = 0; i < 5; i++) begin
      step();
      chk("t1_data", data, 8'h00);
      chk("t1_gnt",  gnt,  2'b00);
      chk("t1_ack",  ack,  2'b00);
      chk("t1_busy", busy, 1'b0);
    end

    // 2: req0 mask 11 data F0
    req = 2'b01; mask[1:0] = 2'b11; wdata[7:0] = 8'hF0;
    step();
    chk("t2_gnt_t1",  gnt,  2'b01);
    chk("t2_busy_t1", busy, 1'b1);
    chk("t2_ack_t1",  ack,  2'b00);
    chk("t2_data_t1", data, 8'h00);
    step();
    chk("t2_gnt_t2",  gnt,  2'b01);
    chk("t2_ack_t2",  ack,  2'b00);
    chk("t2_data_t2", data, 8'h00);
    step();
    chk("t2_gnt_t3",  gnt,  2'b01);
    chk("t2_ack_t3",  ack,  2'b01);
    chk("t2_data_t3", data, 8'hF0);
    req = 2'b00;
    step();
    chk("t2_gnt_t4",  gnt,  2'b00);
    chk("t2_busy_t4", busy, 1'b0);
    chk("t2_ack_t4",  ack,  2'b00);
    chk("t2_data_t4", data, 8'hF0);

    // 3a: req1 mask 01 data 5A -> LSB only
    req = 2'b10; mask[3:2] = 2'b01; wdata[15:8] = 8'h5A;
    step();
    chk("t3a_gnt_t1", gnt, 2'b10);
    chk("t3a_ack_t1", ack, 2'b00);
    step();
    chk("t3a_ack_t2",  ack,  2'b10);
    chk("t3a_data_t2", data, 8'hFA);
    req = 2'b00;
    step();
    chk("t3a_busy_idle", busy, 1'b0);

    // 3b: req1 mask 00 -> ack next cycle, no write
    req = 2'b10; mask[3:2] = 2'b00; wdata[15:8] = 8'h00;
    step();
    chk("t3b_ack_t1",  ack,  2'b10);
    chk("t3b_gnt_t1",  gnt,  2'b10);
    chk("t3b_data_t1", data, 8'hFA);
    req = 2'b00;
    step();
    chk("t3b_ack_t2",  ack,  2'b00);
    chk("t3b_busy_t2", busy, 1'b0);
    chk("t3b_data_t2", data, 8'hFA);

    // 4: both requesting from reset -> 0,1,0,1
    rst = 1'b1;
    step();
    rst = 1'b0;
    chk("t4_data_rst", data, 8'h00);
    req = 2'b11; mask = 4'b1111; wdata = 16'h2211;
    for (int t = 0; t < 4; t++) begin
      exp_owner = ((t % 2) == 0) ? 2'b01 : 2'b10;
      got = 1'b0;
      for (int c = 0; c < 10 && !got; c++) begin
        step();
        if (ack != 2'b00) got = 1'b1;
      end
      chk("t4_ack_seen", got, 1'b1);
      chk("t4_ack_order", ack, exp_owner);
      chk("t4_gnt_owner", gnt, exp_owner);
    end
    req = 2'b00;
    step();
    chk("t4_data_final", data, 8'h22);
    chk("t4_busy_final", busy, 1'b0);

    // 5: reset during HI aborts without ack
    req = 2'b01; mask[1:0] = 2'b11; wdata[7:0] = 8'h3C;
    step();
    chk("t5_gnt_lo", gnt, 2'b01);
    step();
    chk("t5_data_hi", data, 8'h2C);
    rst = 1'b1; req = 2'b00;
    step();
    chk("t5_data_rst", data, 8'h00);
    chk("t5_gnt_rst",  gnt,  2'b00);
    chk("t5_busy_rst", busy, 1'b0);
    chk("t5_ack_rst",  ack,  2'b00);
    rst = 1'b0;
    for (int i = 0; i < 4; i++) begin
      step();
      chk("t5_ack_after", ack, 2'b00);
      chk("t5_busy_after", busy, 1'b0);
    end

    // 6: data/mask changes after acceptance are ignored
    req = 2'b01; mask[1:0] = 2'b11; wdata[7:0] = 8'hA5;
    step();
    chk("t6_gnt_t1", gnt, 2'b01);
    wdata[7:0] = 8'hFF; mask[1:0] = 2'b00;
    step();
    chk("t6_data_t2", data, 8'h05);
    step();
    chk("t6_ack_t3",  ack,  2'b01);
    chk("t6_data_t3", data, 8'hA5);
    req = 2'b00;
    step();
    chk("t6_data_final", data, 8'hA5);
    chk("t6_busy_final", busy, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/slice_write_sched.md
Name: slice_write_sched

Overview:
Arbitrates N_REQ requesters for write access to one W-bit packed register. The register is written as two half-width slices: the LSB slice and the MSB slice, matching the two-modport split used on the shared interface. The block grants one requester at a time in round-robin order. A FSM then applies that requester's masked slice writes, LSB first, one slice per cycle, and acknowledges completion. It sits between requester modules and the shared slice register; o_data drives the register contents onward.

Parameters:
N_REQ, 2, number of requesters (>=2)
W, 8, register width; must be even, slice width is W/2

Ports:
i_clk  input  1  clock; all state updates on rising edge
i_rst  input  1  synchronous active-high reset
i_req  input  N_REQ  per-requester write request; held until matching o_ack
i_mask  input  2*N_REQ  per-requester slice mask {hi,lo}; bit0 = LSB slice, bit1 = MSB slice
i_wdata  input  W*N_REQ  per-requester write data; requester k at [k*W +: W]
o_gnt  output  N_REQ  one-hot, registered; owner of the transaction in flight
o_ack  output  N_REQ  one-cycle registered completion pulse to owner
o_busy  output  1  high whenever FSM is not IDLE
o_data  output  W  current register contents

Behaviour:
- Reset: i_rst sampled high at a clock edge sets state=IDLE, o_data=0, o_gnt=0, o_ack=0, o_busy=0, and rr pointer=0. Reset overrides everything, including mid-transaction; no ack is issued for an aborted transaction.
- FSM states: IDLE, LO, HI, ACK. Encoding comes from the package enum.
- IDLE, cycle T, any i_req high:
  - Round-robin pick: the first requesting index at or after the pointer, wrapping modulo N_REQ.
  - Latch idx, mask[idx] and wdata[idx].
  - From T+1: o_gnt[idx]=1 and o_busy=1.
  - Next state: LO if mask bit0 set; else HI if mask bit1 set; else ACK.
- IDLE with no request: stay; all outputs except o_data are 0.
- LO: write register[W/2-1:0] from latched data[W/2-1:0]. Next state is HI if mask bit1 set, else ACK.
- HI: write register[W-1:W/2] from latched data[W-1:W/2]. Next state is ACK.
- ACK:
  - o_ack[idx]=1 for exactly this cycle; o_gnt[idx] stays high during it.
  - At the end of the cycle, pointer=(idx+1) mod N_REQ and next state is IDLE.
  - o_gnt and o_busy drop in the following cycle.
- o_data is registered and shows a slice update one cycle after that slice's LO/HI cycle.
- Slices not selected by the mask keep their prior value.
- Ack latency from the acceptance edge T:
  - mask 11: ack in cycle T+3
  - mask 01 or 10: ack in cycle T+2
  - mask 00: ack in cycle T+1, with no write
- Latched data is authoritative. Changes to i_wdata, i_mask or i_req after acceptance are ignored, and an in-flight transaction always completes.
- Non-owner requests wait with no starvation: every waiting requester is served within N_REQ transactions.
- Requesters must drop i_req in the cycle after o_ack. A request still high when the FSM returns to IDLE starts a new transaction.
- Minimum spacing between transactions is one IDLE cycle.

Decomposition:
- Package slice_sched_pkg holds:
  - state enum state_e {IDLE, LO, HI, ACK}
  - localparam helper for slice width W/2
  - typedef mask_t = logic [1:0], with constants MASK_LO=2'b01 and MASK_HI=2'b10
- Sub-module rr_arb: combinational N_REQ round-robin picker.
  - Inputs: req vector and pointer.
  - Outputs: one-hot grant and the binary index.
  - Lets the verifier test fairness in isolation.
- The top module holds the FSM, the latches, the register and the pointer update.

Test Plan:
1. Reset, then idle 5 cycles -> o_data=8'h00, o_gnt=0, o_ack=0, o_busy=0 throughout.
2. Req0 with mask 11 and data 8'hF0, accepted at T -> o_data=8'h00 at T+2 (LSB slice written), o_data=8'hF0 at T+3, o_ack[0] pulse in T+3, o_gnt=2'b01 over T+1..T+3.
3. After test 2, req1 with mask 01 and data 8'h5A -> o_data=8'hFA (MSB slice kept), ack at T+2. Then req1 with mask 00 -> ack at T+1 and o_data unchanged.
4. Req0 and req1 asserted together from reset, each holding until acked and immediately re-requesting -> grant order 0,1,0,1; no requester waits more than one transaction.
5. Req0 mask 11 data 8'h3C, i_rst asserted during the HI cycle -> next cycle o_data=8'h00, state IDLE, o_gnt=0, and no o_ack in any cycle.
6. Req0 accepted, then i_wdata changed to 8'hFF the next cycle -> final o_data equals the originally latched value.
